// File: rtl/fcmp_arbiter.sv
// Round-robin arbiter sharing one single-precision compare unit (feq/flt/fle) among NREQ requesters.
// Optional macro FCMP_NV_FLAG_EN adds the registered rsp_nv invalid-operation flag.
module fcmp_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [2*NREQ-1:0]   req_op,
    input  logic [32*NREQ-1:0]  req_x1,
    input  logic [32*NREQ-1:0]  req_x2,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [IDW-1:0]      rsp_id,
    output logic                rsp_y,
    output logic                rsp_err
`ifdef FCMP_NV_FLAG_EN
    ,
    output logic                rsp_nv
`endif
);

    localparam logic [1:0] OP_FEQ = 2'b00;
    localparam logic [1:0] OP_FLT = 2'b01;
    localparam logic [1:0] OP_FLE = 2'b10;

    // Zero-exponent values collapse to +0 so sign-magnitude compares treat -0, +0 and subnormals alike.
    function automatic logic [31:0] fkey(input logic [31:0] v);
        return (v[30:23] == 8'd0) ? 32'd0 : v;
    endfunction

    function automatic logic fnan(input logic [31:0] v);
        return (&v[30:23]) && (|v[22:0]);
    endfunction

    logic                r_rsp_valid;
    logic [IDW-1:0]      r_rsp_id;
    logic                r_rsp_y;
    logic                r_rsp_err;
    logic [IDW-1:0]      r_rr_ptr;

    logic                w_slot_free;
    logic [NREQ-1:0]     w_rot;
    logic                w_grant_any;
    logic [IDW-1:0]      w_grant_idx;
    logic [IDW:0]        w_sum;
    logic                w_accept;
    logic [1:0]          w_sel_op;
    logic [31:0]         w_sel_x1;
    logic [31:0]         w_sel_x2;
    logic [31:0]         w_key1;
    logic [31:0]         w_key2;
    logic                w_any_nan;
    logic                w_eq;
    logic                w_lt;
    logic                w_y;

    assign w_slot_free = !r_rsp_valid || rsp_ready;

    // Rotate so bit 0 is the requester at rr_ptr; the lowest set bit of w_rot wins.
    assign w_rot = NREQ'({req_valid, req_valid} >> r_rr_ptr);

    always_comb begin
        w_grant_any = 1'b0;
        w_grant_idx = '0;
        w_sum       = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_grant_any = 1'b1;
                w_sum       = {1'b0, r_rr_ptr} + (IDW+1)'(k);
                if (w_sum >= (IDW+1)'(NREQ)) begin
                    w_sum = w_sum - (IDW+1)'(NREQ);
                end
                w_grant_idx = w_sum[IDW-1:0];
            end
        end
    end

    assign w_accept = w_slot_free && w_grant_any;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
            assign req_ready[gi] = !rst && w_accept && (w_grant_idx == IDW'(gi));
        end
    endgenerate

    always_comb begin
        w_sel_op = '0;
        w_sel_x1 = '0;
        w_sel_x2 = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (w_grant_idx == IDW'(k)) begin
                w_sel_op = req_op[2*k +: 2];
                w_sel_x1 = req_x1[32*k +: 32];
                w_sel_x2 = req_x2[32*k +: 32];
            end
        end
    end

    assign w_key1    = fkey(w_sel_x1);
    assign w_key2    = fkey(w_sel_x2);
    assign w_any_nan = fnan(w_sel_x1) || fnan(w_sel_x2);
    assign w_eq      = (w_key1 == w_key2);
    // Opposite signs: the negative one is smaller; same sign: magnitude order, reversed when negative.
    assign w_lt      = (w_key1[31] != w_key2[31]) ? w_key1[31] :
                       (w_key1[31] ? (w_key1[30:0] > w_key2[30:0]) : (w_key1[30:0] < w_key2[30:0]));

    always_comb begin
        w_y = 1'b0;
        case (w_sel_op)
            OP_FEQ:  w_y = !w_any_nan && w_eq;
            OP_FLT:  w_y = !w_any_nan && w_lt;
            OP_FLE:  w_y = !w_any_nan && (w_lt || w_eq);
            default: w_y = 1'b0;
        endcase
    end

`ifdef FCMP_NV_FLAG_EN
    logic r_rsp_nv;
    logic w_nv;
    logic w_any_snan;

    assign w_any_snan = (fnan(w_sel_x1) && !w_sel_x1[22]) || (fnan(w_sel_x2) && !w_sel_x2[22]);

    always_comb begin
        w_nv = 1'b0;
        case (w_sel_op)
            OP_FEQ:          w_nv = w_any_snan;
            OP_FLT, OP_FLE:  w_nv = w_any_nan;
            default:         w_nv = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_nv <= 1'b0;
        end else if (w_accept) begin
            r_rsp_nv <= w_nv;
        end
    end

    assign rsp_nv = r_rsp_nv;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_y     <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rr_ptr    <= '0;
        end else if (w_accept) begin
            r_rsp_valid <= 1'b1;
            r_rsp_id    <= w_grant_idx;
            r_rsp_y     <= w_y;
            r_rsp_err   <= (w_sel_op == 2'b11);
            r_rr_ptr    <= (w_grant_idx == IDW'(NREQ - 1)) ? '0 : w_grant_idx + IDW'(1);
        end else if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_y     = r_rsp_y;
    assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_fcmp_arbiter.sv
// Self-checking bench for fcmp_arbiter: directed scenarios plus randomized traffic vs a value-level model.
module tb_fcmp_arbiter;

    localparam int NREQ = 2;
    localparam int IDW  = 3;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [2*NREQ-1:0]   req_op;
    logic [32*NREQ-1:0]  req_x1;
    logic [32*NREQ-1:0]  req_x2;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [IDW-1:0]      rsp_id;
    logic                rsp_y;
    logic                rsp_err;
`ifdef FCMP_NV_FLAG_EN
    logic                rsp_nv;
`endif

    fcmp_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_x1    (req_x1),
        .req_x2    (req_x2),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_y     (rsp_y),
        .rsp_err   (rsp_err)
`ifdef FCMP_NV_FLAG_EN
        ,
        .rsp_nv    (rsp_nv)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: the response slot and the next requester to favour.
    bit m_valid, m_y, m_err, m_nv;
    int m_id, m_rr, m_acc;

    // Real-valued meaning of a float; Inf maps beyond any finite value, NaN is handled separately.
    function automatic real fval(input logic [31:0] v);
        int  e;
        real r;
        e = int'(v[30:23]);
        if (e == 0) r = 0.0;
        else if (e == 255) r = 1.0e300;
        else r = (1.0 + real'(v[22:0]) / 8388608.0) * (2.0 ** (e - 127));
        return v[31] ? -r : r;
    endfunction

    function automatic bit is_nan(input logic [31:0] v);
        return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
    endfunction

    task automatic ref_cmp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           output bit y, output bit nv);
        bit  nan, snan;
        real fa, fb;
        nan  = is_nan(a) || is_nan(b);
        snan = (is_nan(a) && !a[22]) || (is_nan(b) && !b[22]);
        fa = fval(a);
        fb = fval(b);
        y  = 1'b0;
        nv = 1'b0;
        case (op)
            2'b00: begin y = !nan && (fa == fb); nv = snan; end
            2'b01: begin y = !nan && (fa < fb);  nv = nan;  end
            2'b10: begin y = !nan && (fa <= fb); nv = nan;  end
            default: begin y = 1'b0; nv = 1'b0; end
        endcase
    endtask

    function automatic int m_winner();
        int idx;
        if (m_valid && !rsp_ready) return -1;
        for (int k = 0; k < NREQ; k++) begin
            idx = (m_rr + k) % NREQ;
            if (req_valid[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] exp_ready();
        logic [NREQ-1:0] r;
        int w;
        r = '0;
        if (!rst) begin
            w = m_winner();
            if (w >= 0) r[w] = 1'b1;
        end
        return r;
    endfunction

    // Advance one clock, updating the model from the inputs the DUT is about to sample.
    task automatic tick();
        int w;
        bit y, nv;
        logic [1:0] op;
        m_acc = -1;
        if (rst) begin
            m_valid = 0; m_id = 0; m_y = 0; m_err = 0; m_nv = 0; m_rr = 0;
        end else begin
            w = m_winner();
            if (w >= 0) begin
                op = req_op[2*w +: 2];
                ref_cmp(op, req_x1[32*w +: 32], req_x2[32*w +: 32], y, nv);
                m_valid = 1; m_id = w; m_y = y; m_nv = nv; m_err = (op == 2'b11);
                m_rr = (w + 1) % NREQ;
                m_acc = w;
                $display("txn: req%0d op=%b x1=%h x2=%h -> y=%0d err=%0d nv=%0d", w, op,
                         req_x1[32*w +: 32], req_x2[32*w +: 32], y, m_err, nv);
            end else if (m_valid && rsp_ready) begin
                m_valid = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input bit v, input logic [1:0] op,
                           input logic [31:0] a, input logic [31:0] b);
        req_valid[i]      = v;
        req_op[2*i +: 2]  = op;
        req_x1[32*i +: 32] = a;
        req_x2[32*i +: 32] = b;
    endtask

    function automatic logic [31:0] pick_val();
        logic s;
        s = 1'($urandom);
        case ($urandom % 10)
            0: return 32'h0000_0000;
            1: return 32'h8000_0000;
            2: return {s, 8'h00, 23'($urandom)};
            3: return {s, 8'hFF, 23'd0};
            4: return {s, 8'hFF, 1'b1, 22'($urandom)};
            5: return {s, 8'hFF, 1'b0, 21'($urandom), 1'b1};
            6: return {s, 8'd127, 23'd0};
            7: return {1'b0, 8'd128, 23'd0};
            default: return {s, 8'(126 + $urandom % 3), 2'($urandom), 21'd0};
        endcase
    endfunction

    task automatic test_reset();
        rst = 1'b1; rsp_ready = 1'b0;
        set_req(0, 1, 2'b00, 32'h3F80_0000, 32'h3F80_0000);
        set_req(1, 1, 2'b01, 32'h3F80_0000, 32'h4000_0000);
        tick(); tick();
        n_vec++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL reset_ready got=%b exp=00", req_ready); end
        n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", rsp_valid); end
        n_vec++; if (rsp_id !== 3'd0) begin n_err++; $display("FAIL reset_id got=%0d exp=0", rsp_id); end
        n_vec++; if (rsp_y !== 1'b0) begin n_err++; $display("FAIL reset_y got=%b exp=0", rsp_y); end
        n_vec++; if (rsp_err !== 1'b0) begin n_err++; $display("FAIL reset_err got=%b exp=0", rsp_err); end
`ifdef FCMP_NV_FLAG_EN
        n_vec++; if (rsp_nv !== 1'b0) begin n_err++; $display("FAIL reset_nv got=%b exp=0", rsp_nv); end
`endif
        rst = 1'b0; req_valid = '0; rsp_ready = 1'b1;
        #1;
        n_vec++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL idle_ready got=%b exp=00", req_ready); end
        tick();
        n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL idle_valid got=%b exp=0", rsp_valid); end
    endtask

    task automatic test_zero_eq();
        rsp_ready = 1'b1;
        set_req(0, 1, 2'b00, 32'h8000_0000, 32'h0000_0000);
        #1;
        n_vec++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL zero_ready got=%b exp=01", req_ready); end
        tick(); req_valid = '0;
        n_vec++; if (rsp_valid !== 1'b1 || rsp_id !== 3'd0 || rsp_y !== 1'b1 || rsp_err !== 1'b0) begin
            n_err++; $display("FAIL zero_eq got v=%b id=%0d y=%b e=%b exp v=1 id=0 y=1 e=0", rsp_valid, rsp_id, rsp_y, rsp_err);
        end
        set_req(0, 1, 2'b00, 32'h0000_0001, 32'h0000_0000);
        tick(); req_valid = '0;
        n_vec++; if (rsp_valid !== 1'b1 || rsp_id !== 3'd0 || rsp_y !== 1'b1 || rsp_err !== 1'b0) begin
            n_err++; $display("FAIL subnorm_eq got v=%b id=%0d y=%b e=%b exp v=1 id=0 y=1 e=0", rsp_valid, rsp_id, rsp_y, rsp_err);
        end
        tick();
        n_vec++; if (rsp_valid !== 1'b0 || rsp_y !== 1'b1) begin
            n_err++; $display("FAIL drain got v=%b y=%b exp v=0 y=1", rsp_valid, rsp_y);
        end
    endtask

    task automatic test_ordered();
        rsp_ready = 1'b1;
        set_req(1, 1, 2'b01, 32'hBF80_0000, 32'h3F80_0000);
        tick(); req_valid = '0;
        n_vec++; if (rsp_valid !== 1'b1 || rsp_id !== 3'd1 || rsp_y !== 1'b1) begin
            n_err++; $display("FAIL flt_neg got v=%b id=%0d y=%b exp v=1 id=1 y=1", rsp_valid, rsp_id, rsp_y);
        end
        set_req(1, 1, 2'b01, 32'h3F80_0000, 32'hBF80_0000);
        tick(); req_valid = '0;
        n_vec++; if (rsp_id !== 3'd1 || rsp_y !== 1'b0) begin
            n_err++; $display("FAIL flt_swap got id=%0d y=%b exp id=1 y=0", rsp_id, rsp_y);
        end
        set_req(1, 1, 2'b10, 32'h4049_0FDB, 32'h4049_0FDB);
        tick(); req_valid = '0;
        n_vec++; if (rsp_id !== 3'd1 || rsp_y !== 1'b1) begin
            n_err++; $display("FAIL fle_eq got id=%0d y=%b exp id=1 y=1", rsp_id, rsp_y);
        end
        tick();
    endtask

    task automatic test_round_robin();
        rst = 1'b1; tick(); rst = 1'b0;
        rsp_ready = 1'b1;
        set_req(0, 1, 2'b00, 32'h3F80_0000, 32'h3F80_0000);
        set_req(1, 1, 2'b01, 32'h4000_0000, 32'h3F80_0000);
        for (int i = 0; i < 4; i++) begin
            tick();
            n_vec++; if (rsp_valid !== 1'b1 || rsp_id !== 3'(i % 2) || rsp_y !== 1'((i % 2) == 0)) begin
                n_err++; $display("FAIL rr_%0d got v=%b id=%0d y=%b exp v=1 id=%0d y=%0d", i, rsp_valid, rsp_id, rsp_y, i % 2, (i % 2) == 0);
            end
        end
        req_valid = '0;
        tick();
    endtask

    task automatic test_back_to_back();
        rst = 1'b1; tick(); rst = 1'b0;
        rsp_ready = 1'b0;
        set_req(0, 1, 2'b00, 32'h3F80_0000, 32'h4000_0000);
        tick();
        set_req(0, 1, 2'b01, 32'hBF80_0000, 32'h3F80_0000);
        for (int i = 0; i < 3; i++) begin
            #1;
            n_vec++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL bp_ready_%0d got=%b exp=00", i, req_ready); end
            tick();
            n_vec++; if (rsp_valid !== 1'b1 || rsp_id !== 3'd0 || rsp_y !== 1'b0) begin
                n_err++; $display("FAIL bp_hold_%0d got v=%b id=%0d y=%b exp v=1 id=0 y=0", i, rsp_valid, rsp_id, rsp_y);
            end
        end
        rsp_ready = 1'b1;
        #1;
        n_vec++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL bp_release got=%b exp=01", req_ready); end
        tick(); req_valid = '0;
        n_vec++; if (rsp_valid !== 1'b1 || rsp_y !== 1'b1) begin
            n_err++; $display("FAIL bp_overwrite got v=%b y=%b exp v=1 y=1", rsp_valid, rsp_y);
        end
        tick();
        n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL bp_drain got=%b exp=0", rsp_valid); end
    endtask

    task automatic test_illegal_nan();
        logic [1:0]  t_op [6] = '{2'b11, 2'b01, 2'b00, 2'b00, 2'b01, 2'b10};
        logic [31:0] t_a  [6] = '{32'h3F80_0000, 32'h7FC0_0000, 32'h7FC0_0000, 32'h7F80_0001, 32'h3F80_0000, 32'hFF80_0000};
        logic [31:0] t_b  [6] = '{32'h3F80_0000, 32'h3F80_0000, 32'h7FC0_0000, 32'h3F80_0000, 32'h7F80_0000, 32'hFF80_0000};
        bit          t_y  [6] = '{0, 0, 0, 0, 1, 1};
        bit          t_e  [6] = '{1, 0, 0, 0, 0, 0};
        bit          t_nv [6] = '{0, 1, 0, 1, 0, 0};
        rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            set_req(0, 1, t_op[i], t_a[i], t_b[i]);
            tick(); req_valid = '0;
            n_vec++; if (rsp_valid !== 1'b1 || rsp_y !== t_y[i] || rsp_err !== t_e[i]) begin
                n_err++; $display("FAIL special_%0d got v=%b y=%b e=%b exp v=1 y=%0d e=%0d", i, rsp_valid, rsp_y, rsp_err, t_y[i], t_e[i]);
            end
`ifdef FCMP_NV_FLAG_EN
            n_vec++; if (rsp_nv !== t_nv[i]) begin
                n_err++; $display("FAIL special_nv_%0d got=%b exp=%0d", i, rsp_nv, t_nv[i]);
            end
`else
            if (t_nv[i] && t_y[i]) $display("note: entry %0d flags nv and y together", i);
`endif
        end
        tick();
    endtask

    task automatic test_reset_mid();
        rsp_ready = 1'b0;
        set_req(0, 1, 2'b00, 32'h0000_0000, 32'h0000_0000);
        tick(); req_valid = '0;
        n_vec++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL mid_pre got=%b exp=1", rsp_valid); end
        rst = 1'b1; tick(); rst = 1'b0;
        n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL mid_valid got=%b exp=0", rsp_valid); end
        set_req(0, 1, 2'b01, 32'h3F80_0000, 32'h4000_0000);
        set_req(1, 1, 2'b01, 32'h4000_0000, 32'h3F80_0000);
        #1;
        n_vec++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL mid_grant got=%b exp=01", req_ready); end
        tick(); req_valid = '0; rsp_ready = 1'b1;
        n_vec++; if (rsp_id !== 3'd0 || rsp_y !== 1'b1) begin
            n_err++; $display("FAIL mid_first got id=%0d y=%b exp id=0 y=1", rsp_id, rsp_y);
        end
        tick();
    endtask

    task automatic test_random();
        logic [NREQ-1:0] er;
        logic [31:0] a;
        rst = 1'b1; tick(); rst = 1'b0;
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] && ($urandom % 2) == 1) begin
                    a = pick_val();
                    set_req(i, 1, 2'($urandom), a, (($urandom % 4) == 0) ? a : pick_val());
                end
            end
            rsp_ready = ($urandom % 4) != 0;
            rst = ($urandom % 100) == 0;
            #1;
            er = exp_ready();
            n_vec++; if (req_ready !== er) begin
                n_err++; $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, req_ready, er);
            end
            tick();
            if (m_acc >= 0) req_valid[m_acc] = 1'b0;
            rst = 1'b0;
            n_vec++; if (rsp_valid !== m_valid || rsp_id !== 3'(m_id) || rsp_y !== m_y || rsp_err !== m_err) begin
                n_err++; $display("FAIL rnd_rsp c=%0d got v=%b id=%0d y=%b e=%b exp v=%0d id=%0d y=%0d e=%0d",
                                  c, rsp_valid, rsp_id, rsp_y, rsp_err, m_valid, m_id, m_y, m_err);
            end
`ifdef FCMP_NV_FLAG_EN
            n_vec++; if (rsp_nv !== m_nv) begin
                n_err++; $display("FAIL rnd_nv c=%0d got=%b exp=%0d", c, rsp_nv, m_nv);
            end
`endif
        end
        req_valid = '0;
    endtask

    initial begin
        rst = 1'b1; rsp_ready = 1'b0;
        req_valid = '0; req_op = '0; req_x1 = '0; req_x2 = '0;
        m_valid = 0; m_y = 0; m_err = 0; m_nv = 0; m_id = 0; m_rr = 0; m_acc = -1;
        #1;
        test_reset();
        test_zero_eq();
        test_ordered();
        test_round_robin();
        test_back_to_back();
        test_illegal_nan();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
